// File: rtl/password_scan_ctrl_if.sv
// Keypad, ROM and result signals of the password scan controller.
// master = keypad/ROM side, slave = the controller.
interface password_scan_ctrl_if #(
  parameter int ADDR_W = 3
);
  logic [3:0]        digit_in;
  logic              digit_valid;
  logic              clear;
  logic [ADDR_W-1:0] rom_addr;
  logic [15:0]       rom_q;
  logic              busy;
  logic              access_granted;
  logic              access_denied;
  logic [ADDR_W-1:0] user_idx;
  logic              locked;

  modport master (
    output digit_in, digit_valid, clear, rom_q,
    input  rom_addr, busy, access_granted, access_denied, user_idx, locked
  );

  modport slave (
    input  digit_in, digit_valid, clear, rom_q,
    output rom_addr, busy, access_granted, access_denied, user_idx, locked
  );
endinterface

// File: rtl/password_scan_ctrl.sv
// Collects a 4-digit ID, scans the ID ROM for the lowest matching entry, reports grant/deny.
// Optional lockout after repeated denials is built when PWD_LOCKOUT_EN is defined.
module password_scan_ctrl #(
  parameter int NUM_USERS   = 8,
  parameter int ADDR_W      = 3,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024
) (
  input logic                 clk,
  input logic                 reset,
  password_scan_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE, LOCK} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_USERS - 1);

  state_t            state, nextState;
  logic [15:0]       cand;
  logic [1:0]        dcnt;
  logic [ADDR_W-1:0] romAddr;
  logic [ADDR_W-1:0] addrD;     // address whose data is on rom_q this cycle
  logic              primed;    // rom_q holds a scanned entry
  logic [ADDR_W-1:0] userIdx;
  logic              grantFlag;
  logic              hit, lastEntry, lockEnter, lockDone;

  assign hit       = primed && (bus.rom_q == cand);
  assign lastEntry = primed && (addrD == LAST_ADDR);

`ifdef PWD_LOCKOUT_EN
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);

  logic [FAIL_W-1:0] failCnt;
  logic [LOCK_W-1:0] lockCnt;

  assign lockEnter = (failCnt == FAIL_W'(MAX_FAIL - 1));
  assign lockDone  = (lockCnt == '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      failCnt <= '0;
      lockCnt <= '0;
    end else if (state == SCAN && !bus.clear) begin
      if (hit) failCnt <= '0;
      else if (lastEntry) begin
        if (failCnt != FAIL_W'(MAX_FAIL)) failCnt <= failCnt + 1'b1;
        if (lockEnter) lockCnt <= LOCK_W'(LOCK_CYCLES - 1);
      end
    end else if (state == LOCK) begin
      if (lockDone) failCnt <= '0;
      else          lockCnt <= lockCnt - 1'b1;
    end
  end
`else
  assign lockEnter = 1'b0;
  assign lockDone  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (!bus.clear && bus.digit_valid && dcnt == 2'd3) nextState = SCAN;
      // clear beats a same-cycle hit or final miss
      SCAN: if (bus.clear)     nextState = IDLE;
            else if (hit)       nextState = DONE;
            else if (lastEntry) nextState = lockEnter ? LOCK : DONE;
      DONE: if (bus.clear) nextState = IDLE;
      LOCK: if (lockDone) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = 1'b0;
    bus.access_granted = 1'b0;
    bus.access_denied  = 1'b0;
    bus.locked         = 1'b0;
    case (state)
      SCAN: bus.busy = 1'b1;
      DONE: begin
        bus.access_granted = grantFlag;
        bus.access_denied  = !grantFlag;
      end
`ifdef PWD_LOCKOUT_EN
      LOCK: begin
        bus.access_denied = 1'b1;
        bus.locked        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.rom_addr = romAddr;
  assign bus.user_idx = userIdx;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cand      <= '0;
      dcnt      <= '0;
      romAddr   <= '0;
      addrD     <= '0;
      primed    <= 1'b0;
      userIdx   <= '0;
      grantFlag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear) begin
            cand <= '0;
            dcnt <= '0;
          end else if (bus.digit_valid) begin
            cand    <= {cand[11:0], bus.digit_in};
            dcnt    <= dcnt + 2'd1;
            romAddr <= '0;
            primed  <= 1'b0;
          end
        end
        SCAN: begin
          if (bus.clear) begin
            cand    <= '0;
            romAddr <= '0;
          end else begin
            if (romAddr != LAST_ADDR) romAddr <= romAddr + 1'b1;
            addrD  <= romAddr;
            primed <= 1'b1;
            if (hit) begin
              userIdx   <= addrD;
              grantFlag <= 1'b1;
            end else if (lastEntry) begin
              grantFlag <= 1'b0;
            end
          end
        end
        DONE: begin
          if (bus.clear) begin
            cand    <= '0;
            romAddr <= '0;
          end
        end
        default: begin
          if (lockDone) cand <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_password_scan_ctrl.sv
// Randomized bench for password_scan_ctrl against a first-match ROM lookup model.
module tb_password_scan_ctrl;
  localparam int NUM_USERS   = 8;
  localparam int ADDR_W      = 3;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYCLES = 1024;

  logic clk = 1'b0;
  logic reset;
  logic [15:0] rom [NUM_USERS];
  int total = 0;
  int bad = 0;
  int failModel = 0;

  password_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  password_scan_ctrl #(
    .NUM_USERS(NUM_USERS), .ADDR_W(ADDR_W), .MAX_FAIL(MAX_FAIL), .LOCK_CYCLES(LOCK_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_q <= rom[bus.rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic digit(input logic [3:0] d);
    bus.digit_in    = d;
    bus.digit_valid = 1'b1;
    tick();
    bus.digit_valid = 1'b0;
  endtask

  function automatic int firstMatch(input logic [15:0] c);
    for (int i = 0; i < NUM_USERS; i++) if (rom[i] == c) return i;
    return -1;
  endfunction

  task automatic chkIdle(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_gr"},   bus.access_granted, 0);
    chk({tag, "_dn"},   bus.access_denied, 0);
    chk({tag, "_lk"},   bus.locked, 0);
  endtask

  // Full entry: digits with random gaps, stray digits during the scan, result timing check.
  task automatic enterAndCheck(input logic [15:0] cand, input string tag);
    int idx, lat;
    bit lockExp;
    idx = firstMatch(cand);
    for (int n = 3; n >= 0; n--) begin
      repeat ($urandom_range(0, 2)) tick();
      digit(cand[n*4 +: 4]);
    end
    chk({tag, "_scan"}, bus.busy, 1);
    lat = (idx >= 0) ? idx + 2 : NUM_USERS + 1;
    lockExp = 1'b0;
`ifdef PWD_LOCKOUT_EN
    if (idx < 0 && failModel + 1 == MAX_FAIL) lockExp = 1'b1;
`endif
    for (int c = 1; c <= lat; c++) begin
      bus.digit_valid = ($urandom_range(0, 3) == 0);
      bus.digit_in    = 4'($urandom);
      tick();
      if (c < lat) begin
        chk({tag, "_busyMid"}, bus.busy, 1);
        chk({tag, "_resMid"}, {bus.access_granted, bus.access_denied}, 0);
      end
    end
    bus.digit_valid = 1'b0;
    chk({tag, "_busyEnd"}, bus.busy, 0);
    chk({tag, "_gr"}, bus.access_granted, (idx >= 0));
    chk({tag, "_dn"}, bus.access_denied, (idx < 0));
    chk({tag, "_lk"}, bus.locked, lockExp);
    if (idx >= 0) chk({tag, "_idx"}, bus.user_idx, 32'(idx));
    if (idx >= 0) failModel = 0;
    else if (failModel < MAX_FAIL) failModel++;
    if (lockExp) begin
      for (int i = 1; i <= LOCK_CYCLES; i++) begin
        bus.digit_valid = 1'($urandom_range(0, 1));
        bus.clear       = 1'($urandom_range(0, 1));
        bus.digit_in    = 4'($urandom);
        tick();
        chk({tag, "_lockHold"}, bus.locked, (i < LOCK_CYCLES));
        chk({tag, "_lockDn"}, bus.access_denied, (i < LOCK_CYCLES));
      end
      bus.digit_valid = 1'b0;
      bus.clear       = 1'b0;
      failModel = 0;
      chkIdle({tag, "_unlock"});
    end else begin
      digit(4'($urandom));
      chk({tag, "_holdGr"}, bus.access_granted, (idx >= 0));
      chk({tag, "_holdDn"}, bus.access_denied, (idx < 0));
      bus.clear = 1'b1;
      tick();
      bus.clear = 1'b0;
      chkIdle({tag, "_clr"});
    end
  endtask

  initial begin
    rom[0] = 16'h1234; rom[1] = 16'h0042; rom[2] = 16'hBEEF; rom[3] = 16'h0000;
    rom[4] = 16'h9999; rom[5] = 16'h1111; rom[6] = 16'h2222; rom[7] = 16'h3333;
    bus.digit_in = '0; bus.digit_valid = 1'b0; bus.clear = 1'b0;
    reset = 1'b0;
    tick(); tick();
    chkIdle("rst");
    chk("rst_addr", bus.rom_addr, 0);
    chk("rst_idx", bus.user_idx, 0);
    reset = 1'b1;
    tick();

    enterAndCheck(16'hBEEF, "beef");
    enterAndCheck(16'hABCD, "abcd");

    // partial entry discarded by clear
    digit(4'h1); digit(4'h2);
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    enterAndCheck(16'h0042, "partial");

    // clear wins over a same-cycle digit
    digit(4'h1);
    bus.clear = 1'b1; bus.digit_valid = 1'b1; bus.digit_in = 4'h3;
    tick();
    bus.clear = 1'b0; bus.digit_valid = 1'b0;
    enterAndCheck(16'h1111, "clrDigit");

    // abort at E2; entry 3 would otherwise match at E5
    digit(4'h0); digit(4'h0); digit(4'h0); digit(4'h0);
    tick();
    bus.clear = 1'b1; tick(); bus.clear = 1'b0;
    chkIdle("abort");
    repeat (6) tick();
    chk("abortNoRes", {bus.access_granted, bus.access_denied}, 0);
    enterAndCheck(16'h0042, "afterAbort");

    // reset during scan
    digit(4'h9); digit(4'h9); digit(4'h9); digit(4'h9);
    tick(); tick();
    reset = 1'b0; tick();
    chkIdle("midRst");
    chk("midRst_addr", bus.rom_addr, 0);
    chk("midRst_idx", bus.user_idx, 0);
    reset = 1'b1; failModel = 0;
    repeat (12) tick();
    chkIdle("midRstQuiet");

`ifdef PWD_LOCKOUT_EN
    enterAndCheck(16'hABCD, "lk1");
    enterAndCheck(16'hABCD, "lk2");
    enterAndCheck(16'hABCD, "lk3");
    enterAndCheck(16'h1234, "lkAfter");
`endif

    // duplicate-heavy ROM exercises lowest-index-wins
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < NUM_USERS; i++) rom[i] = 16'h1110 + 16'($urandom_range(0, 4));
      enterAndCheck(16'h1110 + 16'($urandom_range(0, 5)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
